uart_tx_frame: RTL

UART transmit framer: accepts a parallel word, serialises it LSB-first into a start / data / optional parity / stop frame paced by an external baud tick, and drives the TX line. It sits directly upstream of `parity_calc`. It presents the latched word on `frame_data` to the parity stage and consumes the returned `parity_bit` during the parity slot.

---
 rtl/uart_tx_frame_pkg.sv | 21 ++
 rtl/uart_tx_frame_if.sv | 23 ++
 rtl/uart_tx_shift.sv | 58 +++++
 rtl/uart_tx_frame.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART transmit definitions: FSM encoding, line levels, counter sizing.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic IdleLevel = 1'b1;
  localparam logic StartBit  = 1'b0;

  // Counter width able to index every bit of a word; at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Handshake and line signals between the TX framer, its requester and the parity stage.
interface uart_tx_frame_if #(
  parameter int unsigned DWIDTH = 8
);
  logic              data_valid;
  logic [DWIDTH-1:0] p_data;
  logic              par_en;
  logic              parity_bit;
  logic [DWIDTH-1:0] frame_data;
  logic              tx_out;
  logic              busy;
  logic              done;

  modport master (
    output data_valid, p_data, par_en, parity_bit,
    input  frame_data, tx_out, busy, done
  );

  modport slave (
    input  data_valid, p_data, par_en, parity_bit,
    output frame_data, tx_out, busy, done
  );
endinterface

// File: rtl/uart_tx_shift.sv
// Data register, bit counter and current/next bit select for the TX framer.
module uart_tx_shift
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              advance_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              first_bit_o,
  output logic              next_bit_o,
  output logic              last_o
);

  localparam int unsigned     CntW    = cnt_width(DWIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(DWIDTH - 1);

  logic [DWIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   next_idx;

  // Latch a new word on accept; step the counter per data tick, saturating at the last bit.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = '0;
    end else if (advance_i && (cnt_q != LastIdx)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Index of the bit that goes out on the next data tick; unused once the last bit is out.
  always_comb begin
    next_idx = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
  end

  // Word and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign first_bit_o = data_q[0];
  assign next_bit_o  = data_q[next_idx];
  assign last_o      = (cnt_q == LastIdx);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start / LSB-first data / optional parity / stop bits, paced by baud_tick.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input logic            clk,
  input logic            rst,
  input logic            baud_tick,
  uart_tx_frame_if.slave bus
);

  localparam logic [1:0] LastStop = 2'(STOP_BITS - 1);

  tx_state_e   state_q, state_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        par_en_q, par_en_d;
  logic [1:0]  stop_cnt_q, stop_cnt_d;

  logic              accept;
  logic              first_bit;
  logic              next_bit;
  logic              last_bit;
  logic [DWIDTH-1:0] frame_data;

  // Requests are only looked at while idle; anything arriving mid-frame is dropped.
  assign accept = (state_q == StIdle) && bus.data_valid;

  uart_tx_shift #(
    .DWIDTH (DWIDTH)
  ) u_shift (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (accept),
    .data_i      (bus.p_data),
    .advance_i   ((state_q == StData) && baud_tick),
    .data_o      (frame_data),
    .first_bit_o (first_bit),
    .next_bit_o  (next_bit),
    .last_o      (last_bit)
  );

  // State and registered outputs; reset forces an idle, high line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      tx_q       <= IdleLevel;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      par_en_q   <= 1'b0;
      stop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      par_en_q   <= par_en_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Next-state: every transition past LOAD waits for a baud tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.data_valid) state_d = StLoad;
      StLoad:   if (baud_tick) state_d = StStart;
      StStart:  if (baud_tick) state_d = StData;
      StData:   if (baud_tick && last_bit) state_d = par_en_q ? StParity : StStop;
      StParity: if (baud_tick) state_d = StStop;
      StStop:   if (baud_tick && (stop_cnt_q == LastStop)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next values: the bit driven on each tick is the one that starts its period there.
  always_comb begin
    tx_d       = tx_q;
    busy_d     = (state_d != StIdle);
    done_d     = 1'b0;
    par_en_d   = par_en_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      StIdle: begin
        tx_d       = IdleLevel;
        stop_cnt_d = '0;
        if (bus.data_valid) par_en_d = bus.par_en;
      end
      StLoad:   if (baud_tick) tx_d = StartBit;
      StStart:  if (baud_tick) tx_d = first_bit;
      StData: begin
        if (baud_tick) begin
          if (last_bit) tx_d = par_en_q ? bus.parity_bit : IdleLevel;
          else          tx_d = next_bit;
        end
      end
      StParity: if (baud_tick) tx_d = IdleLevel;
      StStop: begin
        tx_d = IdleLevel;
        if (baud_tick) begin
          if (stop_cnt_q == LastStop) begin
            done_d     = 1'b1;
            stop_cnt_d = '0;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: tx_d = IdleLevel;
    endcase
  end

  assign bus.frame_data = frame_data;
  assign bus.tx_out     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
